// File: rtl/multi_freq_serial_out_pkg.sv
// Shared definitions for the programmable-rate serial output engine:
// mode encodings and the two-state FSM encoding.
package diff_freq_pkg;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_REPEAT  = 2'b01;
    localparam logic [1:0] MODE_CONT    = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/multi_freq_serial_out_if.sv
// Control, data and status bundle of the serial output engine.
// master drives the request side, slave is the engine itself.
interface multi_freq_serial_out_if #(
    parameter int DATA_BIT = 32,
    parameter int DIV_W    = 16,
    parameter int REPEAT_W = 8
);
    logic                i_start;
    logic                i_stop;
    logic [1:0]          i_mode;
    logic                i_msb_first;
    logic [DIV_W-1:0]    i_divisor;
    logic [REPEAT_W-1:0] i_repeat;
    logic [DATA_BIT-1:0] i_data;

    logic                o_data;
    logic                o_busy;
    logic                o_bit_tick;
    logic                o_frame_tick;
    logic                o_done_tick;

    modport master (
        output i_start, i_stop, i_mode, i_msb_first, i_divisor, i_repeat, i_data,
        input  o_data, o_busy, o_bit_tick, o_frame_tick, o_done_tick
    );

    modport slave (
        input  i_start, i_stop, i_mode, i_msb_first, i_divisor, i_repeat, i_data,
        output o_data, o_busy, o_bit_tick, o_frame_tick, o_done_tick
    );
endinterface

// File: rtl/multi_freq_serial_out_tick_gen.sv
// Programmable rate tick: pulses every i_divisor+1 clocks while enabled,
// counter forced to zero whenever disabled.
module prog_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_divisor,
    output logic             o_tick
);
    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] cnt_next;

    assign o_tick = i_en && (cnt_reg == i_divisor);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (!i_en || o_tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: rtl/multi_freq_serial_out.sv
// Serial output engine: shifts a DATA_BIT word out on one wire at a run-time
// programmable bit rate, with one-shot, counted-repeat and continuous modes.
module multi_freq_serial_out
    import diff_freq_pkg::*;
#(
    parameter int DATA_BIT     = 32,
    parameter int TICK_PER_BIT = 16,
    parameter int DIV_W        = 16,
    parameter int REPEAT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multi_freq_serial_out_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_BIT);
    localparam int TPB_W = (TICK_PER_BIT > 1) ? $clog2(TICK_PER_BIT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BIT - 1);
    localparam logic [TPB_W-1:0] TPB_LAST = TPB_W'(TICK_PER_BIT - 1);
    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_SHIFT = SHIFT;

    logic [0:0]          state_reg,     state_next;
    logic [DATA_BIT-1:0] data_reg,      data_next;
    logic [DIV_W-1:0]    div_reg,       div_next;
    logic [1:0]          mode_reg,      mode_next;
    logic                msb_reg,       msb_next;
    logic [REPEAT_W-1:0] rep_reg,       rep_next;
    logic                stop_reg,      stop_next;
    logic [REPEAT_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic [IDX_W-1:0]    idx_reg,       idx_next;
    logic [TPB_W-1:0]    tpb_cnt_reg,   tpb_cnt_next;

    logic                shifting;
    logic                tick;
    logic                bit_end;
    logic                frame_end;
    logic                final_frame;
    logic [DATA_BIT-1:0] data_rev;

    assign shifting = (state_reg == S_SHIFT);

    prog_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (shifting),
        .i_divisor (div_reg),
        .o_tick    (tick)
    );

    // Mirrored copy of the shadow word so MSB-first is a plain index too.
    for (genvar gi = 0; gi < DATA_BIT; gi++) begin : g_rev
        assign data_rev[gi] = data_reg[DATA_BIT-1-gi];
    end

    assign bit_end   = shifting && tick && (tpb_cnt_reg == TPB_LAST);
    assign frame_end = bit_end && (idx_reg == IDX_LAST);

    // Mode 11 falls through to one-shot; a stop raised in the boundary cycle
    // itself still ends the run on this frame.
    assign final_frame = ((mode_reg != MODE_REPEAT) && (mode_reg != MODE_CONT))
                      || ((mode_reg == MODE_REPEAT) && (frame_cnt_reg == rep_reg))
                      || stop_reg
                      || bus.i_stop;

    assign bus.o_data       = shifting && (msb_reg ? data_rev[idx_reg] : data_reg[idx_reg]);
    assign bus.o_busy       = shifting;
    assign bus.o_bit_tick   = bit_end;
    assign bus.o_frame_tick = frame_end;
    assign bus.o_done_tick  = frame_end && final_frame;

    always_comb begin
        state_next     = state_reg;
        data_next      = data_reg;
        div_next       = div_reg;
        mode_next      = mode_reg;
        msb_next       = msb_reg;
        rep_next       = rep_reg;
        stop_next      = stop_reg;
        frame_cnt_next = frame_cnt_reg;
        idx_next       = idx_reg;
        tpb_cnt_next   = tpb_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.i_start) begin
                    data_next      = bus.i_data;
                    div_next       = bus.i_divisor;
                    mode_next      = bus.i_mode;
                    msb_next       = bus.i_msb_first;
                    rep_next       = bus.i_repeat;
                    stop_next      = 1'b0;
                    frame_cnt_next = '0;
                    idx_next       = '0;
                    tpb_cnt_next   = '0;
                    state_next     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.i_stop) begin
                    stop_next = 1'b1;
                end
                if (tick) begin
                    if (tpb_cnt_reg == TPB_LAST) begin
                        tpb_cnt_next = '0;
                        if (idx_reg == IDX_LAST) begin
                            idx_next = '0;
                            if (final_frame) begin
                                stop_next  = 1'b0;
                                state_next = S_IDLE;
                            end else begin
                                // Mode stays fixed for the whole run; only
                                // data, rate and bit order follow the inputs.
                                data_next = bus.i_data;
                                div_next  = bus.i_divisor;
                                msb_next  = bus.i_msb_first;
                                if (mode_reg == MODE_REPEAT) begin
                                    frame_cnt_next = frame_cnt_reg + 1'b1;
                                end
                            end
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else begin
                        tpb_cnt_next = tpb_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            data_reg      <= '0;
            div_reg       <= '0;
            mode_reg      <= MODE_ONESHOT;
            msb_reg       <= 1'b0;
            rep_reg       <= '0;
            stop_reg      <= 1'b0;
            frame_cnt_reg <= '0;
            idx_reg       <= '0;
            tpb_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            data_reg      <= data_next;
            div_reg       <= div_next;
            mode_reg      <= mode_next;
            msb_reg       <= msb_next;
            rep_reg       <= rep_next;
            stop_reg      <= stop_next;
            frame_cnt_reg <= frame_cnt_next;
            idx_reg       <= idx_next;
            tpb_cnt_reg   <= tpb_cnt_next;
        end
    end
endmodule

// File: tb/tb_multi_freq_serial_out.sv
// Directed bench for multi_freq_serial_out with DATA_BIT=8, TICK_PER_BIT=4.
// Each transfer is captured cycle by cycle, then checked against fixed timings.
module tb_multi_freq_serial_out;
    import diff_freq_pkg::*;

    localparam int DB   = 8;
    localparam int TPB  = 4;
    localparam int DW   = 16;
    localparam int RW   = 8;
    localparam int NCAP = 200;
    localparam int K_BIT   = 0;
    localparam int K_FRAME = 1;
    localparam int K_DONE  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_freq_serial_out_if #(.DATA_BIT(DB), .DIV_W(DW), .REPEAT_W(RW)) bus ();

    multi_freq_serial_out #(
        .DATA_BIT     (DB),
        .TICK_PER_BIT (TPB),
        .DIV_W        (DW),
        .REPEAT_W     (RW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic cap_data  [1:NCAP];
    logic cap_busy  [1:NCAP];
    logic cap_bit   [1:NCAP];
    logic cap_frame [1:NCAP];
    logic cap_done  [1:NCAP];

    int          act_cyc;
    int          stop_cyc;
    int          start2_cyc;
    logic [7:0]  act_data;
    logic [15:0] act_div;
    logic [1:0]  act_mode;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Start request presented for the edge that opens cycle 1.
    task automatic kick(input logic [1:0] mode, input logic msb, input logic [15:0] div,
                        input logic [7:0] rep, input logic [7:0] data, input logic stop);
        @(negedge clk);
        bus.i_mode      = mode;
        bus.i_msb_first = msb;
        bus.i_divisor   = div;
        bus.i_repeat    = rep;
        bus.i_data      = data;
        bus.i_stop      = stop;
        bus.i_start     = 1'b1;
        act_cyc    = -1;
        stop_cyc   = -1;
        start2_cyc = -1;
    endtask

    task automatic capture(input string name, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            bus.i_start = (c == start2_cyc);
            bus.i_stop  = (c == stop_cyc);
            if (c == act_cyc) begin
                bus.i_data    = act_data;
                bus.i_divisor = act_div;
                bus.i_mode    = act_mode;
            end
            #1;
            cap_data[c]  = bus.o_data;
            cap_busy[c]  = bus.o_busy;
            cap_bit[c]   = bus.o_bit_tick;
            cap_frame[c] = bus.o_frame_tick;
            cap_done[c]  = bus.o_done_tick;
        end
        $display("xfer %s: %0d cycles captured", name, ncyc);
    endtask

    function automatic int count_hi(input int which, input int a, input int b);
        int n = 0;
        for (int c = a; c <= b; c++) begin
            case (which)
                K_BIT:   n += int'(cap_bit[c]);
                K_FRAME: n += int'(cap_frame[c]);
                default: n += int'(cap_done[c]);
            endcase
        end
        return n;
    endfunction

    // Bit k of a frame starting at cycle 'first' spans first+k*p .. first+(k+1)*p-1.
    task automatic check_frame(input string tag, input int first, input int p,
                               input logic [7:0] word, input logic msb);
        logic exp_bit;
        int   s;
        int   e;
        for (int k = 0; k < DB; k++) begin
            exp_bit = msb ? word[DB-1-k] : word[k];
            s = first + k * p;
            e = first + (k + 1) * p - 1;
            check_value($sformatf("%s bit%0d first", tag, k), 32'(cap_data[s]), 32'(exp_bit));
            check_value($sformatf("%s bit%0d last", tag, k), 32'(cap_data[e]), 32'(exp_bit));
            check_value($sformatf("%s bit%0d tick", tag, k), 32'(cap_bit[e]), 32'd1);
            if (p > 1) begin
                check_value($sformatf("%s bit%0d notick", tag, k), 32'(cap_bit[s]), 32'd0);
            end
        end
    endtask

    logic seen_after_rst;

    initial begin
        rst_n           = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_stop      = 1'b0;
        bus.i_mode      = MODE_ONESHOT;
        bus.i_msb_first = 1'b0;
        bus.i_divisor   = '0;
        bus.i_repeat    = '0;
        bus.i_data      = '0;
        act_cyc    = -1;
        stop_cyc   = -1;
        start2_cyc = -1;
        act_data   = '0;
        act_div    = '0;
        act_mode   = MODE_ONESHOT;

        #12;
        check_value("rst o_data", 32'(bus.o_data), 32'd0);
        check_value("rst o_busy", 32'(bus.o_busy), 32'd0);
        check_value("rst bit_tick", 32'(bus.o_bit_tick), 32'd0);
        check_value("rst frame_tick", 32'(bus.o_frame_tick), 32'd0);
        check_value("rst done_tick", 32'(bus.o_done_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot, MSB first, divisor 1: 8 clocks per bit, done at 64.
        kick(MODE_ONESHOT, 1'b1, 16'd1, 8'd0, 8'hA5, 1'b0);
        capture("oneshot A5 msb", 66);
        check_frame("a5m", 1, 8, 8'hA5, 1'b1);
        check_value("a5m bit ticks", 32'(count_hi(K_BIT, 1, 66)), 32'd8);
        check_value("a5m frame@64", 32'(cap_frame[64]), 32'd1);
        check_value("a5m done@64", 32'(cap_done[64]), 32'd1);
        check_value("a5m frame cnt", 32'(count_hi(K_FRAME, 1, 66)), 32'd1);
        check_value("a5m busy@1", 32'(cap_busy[1]), 32'd1);
        check_value("a5m busy@64", 32'(cap_busy[64]), 32'd1);
        check_value("a5m busy@65", 32'(cap_busy[65]), 32'd0);
        check_value("a5m data@65", 32'(cap_data[65]), 32'd0);

        kick(MODE_ONESHOT, 1'b1, 16'd1, 8'd0, 8'h3C, 1'b0);
        capture("oneshot 3C msb", 66);
        check_frame("3cm", 1, 8, 8'h3C, 1'b1);
        check_value("3cm done@64", 32'(cap_done[64]), 32'd1);

        kick(MODE_ONESHOT, 1'b0, 16'd1, 8'd0, 8'h3C, 1'b0);
        capture("oneshot 3C lsb", 66);
        check_frame("3cl", 1, 8, 8'h3C, 1'b0);
        check_value("3cl done@64", 32'(cap_done[64]), 32'd1);

        // Repeat x3, divisor 0; data changed in frame 1 shows up from frame 2.
        kick(MODE_REPEAT, 1'b1, 16'd0, 8'd2, 8'h96, 1'b0);
        act_cyc = 10; act_data = 8'h5A; act_div = 16'd0; act_mode = MODE_REPEAT;
        capture("repeat3 96/5A", 98);
        check_frame("rp f1", 1, 4, 8'h96, 1'b1);
        check_frame("rp f2", 33, 4, 8'h5A, 1'b1);
        check_frame("rp f3", 65, 4, 8'h5A, 1'b1);
        check_value("rp frame cnt", 32'(count_hi(K_FRAME, 1, 98)), 32'd3);
        check_value("rp done cnt", 32'(count_hi(K_DONE, 1, 98)), 32'd1);
        check_value("rp done@96", 32'(cap_done[96]), 32'd1);
        check_value("rp busy@97", 32'(cap_busy[97]), 32'd0);

        // Continuous: divisor 3 -> 0 and mode input changed in frame 1; stop mid frame 2.
        kick(MODE_CONT, 1'b1, 16'd3, 8'd0, 8'hE1, 1'b0);
        act_cyc = 20; act_data = 8'h4D; act_div = 16'd0; act_mode = MODE_ONESHOT;
        stop_cyc = 140;
        capture("cont E1/4D", 162);
        check_frame("ct f1", 1, 16, 8'hE1, 1'b1);
        check_frame("ct f2", 129, 4, 8'h4D, 1'b1);
        check_value("ct frame@128", 32'(cap_frame[128]), 32'd1);
        check_value("ct done@128", 32'(cap_done[128]), 32'd0);
        check_value("ct frame cnt", 32'(count_hi(K_FRAME, 1, 162)), 32'd2);
        check_value("ct done@160", 32'(cap_done[160]), 32'd1);
        check_value("ct done cnt", 32'(count_hi(K_DONE, 1, 162)), 32'd1);
        check_value("ct busy@161", 32'(cap_busy[161]), 32'd0);

        // Stop raised exactly in the frame's last cycle ends the run there.
        kick(MODE_CONT, 1'b1, 16'd0, 8'd0, 8'h0F, 1'b0);
        stop_cyc = 32;
        capture("cont stop@end", 34);
        check_value("se done@32", 32'(cap_done[32]), 32'd1);
        check_value("se frame cnt", 32'(count_hi(K_FRAME, 1, 34)), 32'd1);
        check_value("se busy@33", 32'(cap_busy[33]), 32'd0);

        // Start during SHIFT ignored, data input change mid-frame not taken.
        kick(MODE_ONESHOT, 1'b0, 16'd0, 8'd0, 8'h0B, 1'b0);
        start2_cyc = 10;
        act_cyc = 10; act_data = 8'hFF; act_div = 16'd0; act_mode = MODE_ONESHOT;
        capture("start in shift", 35);
        check_frame("ss", 1, 4, 8'h0B, 1'b0);
        check_value("ss done@32", 32'(cap_done[32]), 32'd1);
        check_value("ss busy@33", 32'(cap_busy[33]), 32'd0);
        check_value("ss busy@34", 32'(cap_busy[34]), 32'd0);
        check_value("ss busy@35", 32'(cap_busy[35]), 32'd0);

        // Stop in IDLE ignored: the following continuous run must not end at frame 1.
        @(negedge clk);
        bus.i_stop = 1'b1;
        kick(MODE_CONT, 1'b1, 16'd0, 8'd0, 8'hC3, 1'b0);
        stop_cyc = 40;
        capture("stop in idle", 66);
        check_value("si done 1..32", 32'(count_hi(K_DONE, 1, 32)), 32'd0);
        check_value("si busy@33", 32'(cap_busy[33]), 32'd1);
        check_frame("si f2", 33, 4, 8'hC3, 1'b1);
        check_value("si done@64", 32'(cap_done[64]), 32'd1);
        check_value("si busy@65", 32'(cap_busy[65]), 32'd0);

        // Start and stop together in IDLE: stop dropped, both repeat frames sent.
        kick(MODE_REPEAT, 1'b1, 16'd0, 8'd1, 8'h69, 1'b1);
        capture("start+stop", 66);
        check_value("sp frame@32", 32'(cap_frame[32]), 32'd1);
        check_value("sp done@32", 32'(cap_done[32]), 32'd0);
        check_value("sp done@64", 32'(cap_done[64]), 32'd1);
        check_value("sp busy@65", 32'(cap_busy[65]), 32'd0);

        // Mode 11 acts as one-shot; restart in the single idle cycle is accepted.
        kick(2'b11, 1'b1, 16'd0, 8'd0, 8'h96, 1'b0);
        start2_cyc = 33;
        capture("mode11 b2b", 66);
        check_value("m3 done@32", 32'(cap_done[32]), 32'd1);
        check_value("m3 busy@33", 32'(cap_busy[33]), 32'd0);
        check_value("m3 data@33", 32'(cap_data[33]), 32'd0);
        check_value("m3 busy@34", 32'(cap_busy[34]), 32'd1);
        check_frame("m3 f2", 34, 4, 8'h96, 1'b1);
        check_value("m3 done@65", 32'(cap_done[65]), 32'd1);
        check_value("m3 busy@66", 32'(cap_busy[66]), 32'd0);

        // Asynchronous reset in the middle of bit 3.
        kick(MODE_ONESHOT, 1'b1, 16'd1, 8'd0, 8'hFF, 1'b0);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (27) @(negedge clk);
        check_value("ar pre data", 32'(bus.o_data), 32'd1);
        check_value("ar pre busy", 32'(bus.o_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("ar o_data", 32'(bus.o_data), 32'd0);
        check_value("ar o_busy", 32'(bus.o_busy), 32'd0);
        check_value("ar frame_tick", 32'(bus.o_frame_tick), 32'd0);
        check_value("ar done_tick", 32'(bus.o_done_tick), 32'd0);
        seen_after_rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_after_rst = seen_after_rst | bus.o_done_tick | bus.o_busy | bus.o_data;
        end
        check_value("ar held quiet", 32'(seen_after_rst), 32'd0);
        rst_n = 1'b1;
        $display("xfer reset mid-bit: truncated at bit 3");

        kick(MODE_ONESHOT, 1'b1, 16'd0, 8'd0, 8'h96, 1'b0);
        capture("after reset", 34);
        check_frame("pr", 1, 4, 8'h96, 1'b1);
        check_value("pr done@32", 32'(cap_done[32]), 32'd1);
        check_value("pr busy@33", 32'(cap_busy[33]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multi_freq_serial_out.md
# multi_freq_serial_out

Parametrised serial output engine: shifts a DATA_BIT-wide word out on one wire at a run-time-programmable bit rate. Supports one-shot, counted-repeat and continuous modes, selectable bit order, and graceful stop. In continuous and counted-repeat modes, data and rate are re-latched at each frame boundary, so frequency can change on the fly. It replaces fixed two-frequency serial output in pattern-generation paths and feeds the same downstream pin logic (idle-low output).

## Interface
- DATA_BIT, 32: bits per frame (≥2)
- TICK_PER_BIT, 16: rate ticks per output bit (≥1)
- DIV_W, 16: width of rate divisor
- REPEAT_W, 8: width of repeat count
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request, sampled in IDLE only
- i_stop  in  1  graceful stop request, sampled while busy
- i_mode  in  2  00 one-shot, 01 repeat-N, 10 continuous, 11 treated as one-shot
- i_msb_first  in  1  1 = MSB first, 0 = LSB first
- i_divisor  in  DIV_W  rate tick period = i_divisor+1 clocks
- i_repeat  in  REPEAT_W  repeat-N mode: frames sent = i_repeat+1
- i_data  in  DATA_BIT  frame data
- o_data  out  1  serial output; low when idle
- o_busy  out  1  high from cycle after accepted start until the last bit ends
- o_bit_tick  out  1  one-cycle pulse in last cycle of each bit
- o_frame_tick  out  1  one-cycle pulse in last cycle of each frame
- o_done_tick  out  1  one-cycle pulse in last cycle of the final frame

## Operation
- States: IDLE, SHIFT.
- IDLE: o_data=0, o_busy=0, tick generator held at 0. When i_start=1:
  - latch i_data, i_divisor, i_mode, i_msb_first, i_repeat
  - clear bit index and stop flag
  - go to SHIFT
- SHIFT: o_data = latched word bit (index, or DATA_BIT-1-index when MSB first). Rate counter counts 0..divisor and pulses at divisor. Bit ends on TICK_PER_BIT-th pulse.
- End of a non-final bit: index+1.
- End of frame (index = DATA_BIT-1): o_frame_tick. Frame is final if any of:
  - one-shot mode
  - repeat-N with frame counter = latched repeat
  - stop flag set
  - stop asserted in this cycle
- Final frame: o_done_tick, return to IDLE.
- Non-final frame:
  - re-latch i_data, i_divisor, i_msb_first
  - repeat-N: frame counter +1
  - continuous: frame counter unchanged, so it cannot overflow
  - index=0, stay in SHIFT with no gap
- i_mode is not re-latched mid-operation.
- i_stop in SHIFT sets a sticky stop flag; the current frame always completes. i_stop in IDLE is ignored.
- i_start in SHIFT is ignored.
- i_start and i_stop together in IDLE: start accepted, stop dropped.
- Divisor 0 is legal: one tick per clock, bit = TICK_PER_BIT clocks.
- Repeat count 0 in repeat-N mode equals one-shot.

## Timing
- Reset (async, any state): state IDLE, all counters 0, o_data=0, o_busy=0, o_bit_tick=0, o_frame_tick=0, o_done_tick=0. Reset mid-frame truncates output immediately; no done tick.
- Start sampled at edge T: from cycle T+1, o_busy=1 and o_data = first bit.
- Bit period P = TICK_PER_BIT·(divisor+1) clocks. Bit k occupies cycles T+1+kP … T+(k+1)P.
- o_bit_tick is high in cycle T+(k+1)P.
- Last bit: o_frame_tick and o_done_tick coincide with the final o_bit_tick. In the next cycle, o_data=0 and o_busy=0.
- A new start is accepted in that same cycle, so there is 1 idle cycle minimum between transfers.
- Re-latched divisor applies from the first cycle of the next frame.

## Structure
- Shared package diff_freq_pkg:
  - mode encodings MODE_ONESHOT, MODE_REPEAT, MODE_CONT
  - state enum IDLE/SHIFT
- Sub-module prog_tick_gen (DIV_W):
  - inputs clk, rst_n, i_en, i_divisor
  - output o_tick
  - counter cleared when i_en=0
  - replaces fixed mod-M counters
- Top module holds the FSM, tick-per-bit counter ($clog2(TICK_PER_BIT) bits), bit index ($clog2(DATA_BIT)), frame counter (REPEAT_W) and shadow registers.

## Test plan
All scenarios use DATA_BIT=8, TICK_PER_BIT=4.
- One-shot, divisor=1, data 0xA5, MSB first, start at T:
  - o_data 1,0,1,0,0,1,0,1, each 8 clocks
  - 8 bit ticks; frame/done ticks at T+64
  - o_busy low at T+65
- Same with LSB first: sequence 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 → verify against 0x3C instead:
  - MSB first gives 0,0,1,1,1,1,0,0
  - LSB first gives 0,0,1,1,1,1,0,0 mirrored per index
  - check each bit per index
- Repeat-N, repeat=2, divisor=0:
  - three frames of 32 clocks back-to-back
  - 3 frame ticks, 1 done tick at T+96
  - i_data changed mid-frame 1 appears in frame 2
- Continuous, divisor 3 changed to 0 during frame 1:
  - frame 1 uses 16 clocks/bit, frame 2 uses 4 clocks/bit
  - i_stop pulsed mid-frame 2 → done at end of frame 2
- Boundary cases:
  - start during SHIFT ignored
  - stop in IDLE ignored
  - start+stop same cycle in IDLE → full frame sent
  - i_mode=11 → one-shot
- rst_n low mid-bit 3: all outputs 0 asynchronously, no done tick; after release, a new start sends a complete frame.
